// File: rtl/tx_seq_ctrl.sv
// Transmit sequencer: SYNC byte, N payload bytes from the FIFO, then a 3-bit-period EOP.
// Optional macro TX_SEQ_ABORT_EN enables tx_abort (SYNC/DATA jump straight to EOP).
module tx_seq_ctrl #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [6:0] tx_num_bytes,
    input  logic       fifo_empty,
    input  logic       tx_abort,
    output logic       load_sync,
    output logic       load_byte,
    output logic       shift_strobe,
    output logic       tx_eop,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;

    localparam logic [5:0] TIMER_LAST = 6'(CLKS_PER_BIT - 1);

    state_t     state_q, state_d;
    logic [5:0] timer_q, timer_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [6:0] remaining_q, remaining_d;
    logic       strobe;
    logic       abort_req;

`ifdef TX_SEQ_ABORT_EN
    assign abort_req = tx_abort;
`else
    logic unused_abort;
    assign unused_abort = tx_abort;
    assign abort_req    = 1'b0;
`endif

    assign strobe = (state_q != IDLE) && (timer_q == TIMER_LAST);

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bitcnt_d     = bitcnt_q;
        remaining_d  = remaining_q;
        load_sync    = 1'b0;
        load_byte    = 1'b0;
        tx_eop       = 1'b0;
        tx_done      = 1'b0;
        tx_error     = 1'b0;
        shift_strobe = strobe;
        tx_busy      = (state_q != IDLE);

        if (state_q != IDLE) begin
            timer_d = strobe ? 6'd0 : timer_q + 6'd1;
            if (strobe) begin
                bitcnt_d = bitcnt_q + 3'd1;
            end
        end

        case (state_q)
            IDLE: begin
                timer_d  = 6'd0;
                bitcnt_d = 3'd0;
                if (tx_start) begin
                    remaining_d = (tx_num_bytes > 7'd64) ? 7'd64 : tx_num_bytes;
                    state_d     = SYNC;
                end
            end
            SYNC, DATA: begin
                // Timer and bit counter are both zero only in the first SYNC cycle.
                load_sync = (state_q == SYNC) && (timer_q == 6'd0) && (bitcnt_q == 3'd0);
                if (abort_req) begin
                    state_d  = EOP;
                    timer_d  = 6'd0;
                    bitcnt_d = 3'd0;
                end else if (strobe && (bitcnt_q == 3'd7)) begin
                    if (remaining_q == 7'd0) begin
                        state_d = EOP;
                    end else if (!fifo_empty) begin
                        load_byte   = 1'b1;
                        remaining_d = remaining_q - 7'd1;
                        state_d     = DATA;
                    end else begin
                        tx_error = 1'b1;
                        state_d  = EOP;
                    end
                end
            end
            EOP: begin
                // Two bit periods of SE0, then one idle-J period.
                tx_eop = (bitcnt_q < 3'd2);
                if (strobe && (bitcnt_q == 3'd2)) begin
                    tx_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            timer_q     <= 6'd0;
            bitcnt_q    <= 3'd0;
            remaining_q <= 7'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bitcnt_q    <= bitcnt_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_tx_seq_ctrl.sv
// Self-checking bench for tx_seq_ctrl: per-packet event timing derived from packet length,
// FIFO occupancy and abort cycle, compared cycle by cycle.
module tb_tx_seq_ctrl;

    localparam int P = 8;
    localparam int BYTE_CYC = 8 * P;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [6:0] tx_num_bytes = 7'd0;
    logic       fifo_empty = 1'b1;
    logic       tx_abort = 1'b0;
    logic       load_sync, load_byte, shift_strobe, tx_eop, tx_busy, tx_done, tx_error;

    int checks = 0;
    int failures = 0;

    tx_seq_ctrl #(.CLKS_PER_BIT(P)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .tx_start     (tx_start),
        .tx_num_bytes (tx_num_bytes),
        .fifo_empty   (fifo_empty),
        .tx_abort     (tx_abort),
        .load_sync    (load_sync),
        .load_byte    (load_byte),
        .shift_strobe (shift_strobe),
        .tx_eop       (tx_eop),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_error     (tx_error)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {load_sync, load_byte, shift_strobe, tx_eop, tx_busy, tx_done, tx_error};
    endfunction

    // Drive one packet accepted at cycle 0 and check every cycle through the first idle cycle.
    task automatic run_packet(input int nreq, input int fifo_init, input int abort_at,
                              input int start2_at, input string name);
        int n, loads, err, e_nat, e, d, cut, fifo_cnt, mism, first_c, obs_done, nloads, exp_loads;
        bit abort_eff;
        logic [6:0] obs, exp_v, first_obs, first_exp;
        n = (nreq > 64) ? 64 : nreq;
        loads = (fifo_init < n) ? fifo_init : n;
        err = (fifo_init < n) ? 1 : 0;
        e_nat = BYTE_CYC * (loads + 1) + 1;
`ifdef TX_SEQ_ABORT_EN
        abort_eff = (abort_at > 0) && (abort_at < e_nat);
`else
        abort_eff = 1'b0;
`endif
        e = abort_eff ? abort_at + 1 : e_nat;
        cut = abort_eff ? abort_at : 1 << 30;
        d = e + 3 * P - 1;
        exp_loads = 0;
        for (int k = 1; k <= loads; k++) if (BYTE_CYC * k < cut) exp_loads++;
        mism = 0; first_c = 0; first_obs = '0; first_exp = '0; obs_done = -1; nloads = 0;
        fifo_cnt = fifo_init;

        @(negedge clk);
        tx_start = 1'b1;
        tx_num_bytes = 7'(nreq);
        tx_abort = 1'b0;
        fifo_empty = (fifo_cnt == 0);
        @(posedge clk);
        for (int c = 1; c <= d + 1; c++) begin
            @(negedge clk);
            tx_start = (c == start2_at);
            if (c == start2_at) tx_num_bytes = 7'($urandom_range(1, 64));
            tx_abort = (c == abort_at);
            fifo_empty = (fifo_cnt == 0);
            #1;
            obs = outs();
            exp_v[6] = (c == 1);
            exp_v[5] = (c % BYTE_CYC == 0) && (c / BYTE_CYC >= 1) && (c / BYTE_CYC <= loads) && (c < cut);
            exp_v[4] = (c <= d) && (((c < e) && (c % P == 0)) || ((c >= e) && ((c - e) % P == P - 1)));
            exp_v[3] = (c >= e) && (c < e + 2 * P);
            exp_v[2] = (c <= d);
            exp_v[1] = (c == d);
            exp_v[0] = (err != 0) && (c == BYTE_CYC * (loads + 1)) && (c < cut);
            if (obs !== exp_v) begin
                if (mism == 0) begin
                    first_c = c; first_obs = obs; first_exp = exp_v;
                end
                mism++;
            end
            if (tx_done === 1'b1) obs_done = c;
            if (load_byte === 1'b1) begin
                nloads++;
                if (fifo_cnt > 0) fifo_cnt--;
            end
        end
        tx_start = 1'b0;
        tx_abort = 1'b0;

        checks++;
        if (mism != 0) begin
            failures++;
            $display("FAIL %s trace: %0d bad cycles, first at cycle %0d got %b expected %b (ls lb ss eop busy done err)",
                     name, mism, first_c, first_obs, first_exp);
        end
        checks++;
        if (obs_done != d) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, obs_done, d);
        end
        checks++;
        if (nloads != exp_loads) begin
            failures++;
            $display("FAIL %s load_count: got %0d expected %0d", name, nloads, exp_loads);
        end
        $display("pkt %s: nreq=%0d fifo=%0d abort=%0d done@%0d (exp %0d) loads=%0d",
                 name, nreq, fifo_init, abort_at, obs_done, d, nloads);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (outs() !== 7'b0) begin
                failures++;
                $display("FAIL %s outputs: got %b expected 0000000", name, outs());
            end
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        tx_start = 1'b1;
        tx_num_bytes = 7'd5;
        fifo_empty = 1'b0;
        expect_quiet("reset_active", 3);
        @(negedge clk);
        tx_start = 1'b0;
        n_rst = 1'b1;
        expect_quiet("after_reset", 3);
        $display("reset: outputs idle during and after reset");
    endtask

    task automatic test_spec_cases();
        run_packet(1, 5, 0, 0, "n1");
        run_packet(0, 5, 0, 0, "n0");
        run_packet(2, 1, 0, 0, "underrun");
    endtask

    task automatic test_clamp();
        run_packet(100, 100, 0, 50, "clamp100");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        tx_start = 1'b1;
        tx_num_bytes = 7'd3;
        fifo_empty = 1'b0;
        @(posedge clk);
        for (int c = 1; c < 70; c++) begin
            @(negedge clk);
            tx_start = 1'b0;
        end
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        checks++;
        if (outs() !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid immediate: got %b expected 0000000", outs());
        end
        expect_quiet("reset_mid_hold", 3);
        @(negedge clk);
        n_rst = 1'b1;
        expect_quiet("reset_mid_release", 4);
        $display("reset_mid: reset at cycle 70 of N=3 packet");
        run_packet(2, 4, 0, 0, "after_reset_mid");
    endtask

    task automatic test_abort();
        run_packet(3, 10, 100, 0, "abort100");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            int nreq, fifo_init, abort_at;
            nreq = $urandom_range(0, 6);
            fifo_init = $urandom_range(0, nreq + 1);
            abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(2, BYTE_CYC * (nreq + 2)) : 0;
            run_packet(nreq, fifo_init, abort_at, ($urandom_range(0, 1) == 1) ? 30 : 0, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_packet(1, 1, 0, 0, "b2b_a");
        run_packet(1, 0, 0, 0, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_spec_cases();
        test_clamp();
        test_reset_mid();
        test_abort();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_seq_ctrl.md
TX_SEQ_CTRL -- requirements
Module: tx_seq_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8, means clock cycles per serial bit period; legal range 2..63.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 tx_start  input  1  request to send one packet; sampled only in IDLE.
REQ-005 tx_num_bytes  input  7  payload byte count (0..64), captured when tx_start is accepted.
REQ-006 fifo_empty  input  1  TX data FIFO holds no byte.
REQ-007 tx_abort  input  1  abort request (functional only with TX_SEQ_ABORT_EN).
REQ-008 load_sync  output  1  one-cycle pulse: shifter loads SYNC byte.
REQ-009 load_byte  output  1  one-cycle pulse: shifter pops and loads next FIFO byte.
REQ-010 shift_strobe  output  1  one-cycle pulse at end of every bit period.
REQ-011 tx_eop  output  1  level, high while SE0 portion of EOP is driven.
REQ-012 tx_busy  output  1  level, high in any state other than IDLE.
REQ-013 tx_done  output  1  one-cycle pulse at packet completion.
REQ-014 tx_error  output  1  one-cycle pulse on FIFO underrun.

Function
REQ-015 FSM states SHALL be IDLE, SYNC, DATA, EOP; encoding free.
REQ-016 Bit timer SHALL count 0..CLKS_PER_BIT-1, clear to 0 on every state entry, and assert shift_strobe in the cycle it equals CLKS_PER_BIT-1, then wrap to 0.
REQ-017 Bit counter (3 bits) SHALL advance on each shift_strobe, clear on state entry; byte end = 8th strobe in SYNC/DATA.
REQ-018 IDLE: tx_start=1 at edge SHALL capture min(tx_num_bytes,64) into remaining counter and enter SYNC next cycle; load_sync=1 in first SYNC cycle only.
REQ-019 tx_start while tx_busy=1 SHALL be ignored with no side effect.
REQ-020 At byte end in SYNC or DATA: remaining=0 -> enter EOP; remaining>0 and fifo_empty=0 -> load_byte=1 that cycle, remaining decrements, enter DATA; remaining>0 and fifo_empty=1 -> tx_error=1 that cycle, enter EOP.
REQ-021 EOP SHALL last 3 bit periods; tx_eop=1 for first 2 periods (2*CLKS_PER_BIT cycles), 0 for the third.
REQ-022 tx_done SHALL pulse on the 3rd EOP shift_strobe cycle; IDLE entered next cycle.
REQ-023 load_sync, load_byte, tx_done, tx_error SHALL never assert in the same cycle as each other.
REQ-024 Per-packet cycle count from accepted tx_start to tx_done = CLKS_PER_BIT*(8*(N+1)+3) with N bytes, no underrun.
REQ-025 shift_strobe SHALL be 0 in IDLE.

Reset
REQ-026 n_rst=0 SHALL immediately force IDLE, clear bit timer, bit counter, remaining counter, regardless of state.
REQ-027 During and after reset all outputs SHALL be 0 until a tx_start is accepted.
REQ-028 Reset mid-packet SHALL produce no tx_done or tx_error pulse.

Configuration
REQ-029 Macro TX_SEQ_ABORT_EN defined: tx_abort=1 in SYNC or DATA SHALL enter EOP next cycle with bit timer cleared; no load_byte that cycle; tx_error not asserted; abort ignored in IDLE and EOP.
REQ-030 Macro TX_SEQ_ABORT_EN undefined: tx_abort port SHALL remain present and be ignored entirely.

Verification (CLKS_PER_BIT=8, tx_start accepted at edge of cycle 0)
REQ-031 N=1, fifo non-empty -> load_sync cycle 1; strobes cycles 8,16..; load_byte cycle 64; tx_eop high cycles 129-144; tx_done cycle 152; tx_busy low from 153.
REQ-032 N=0 -> no load_byte; EOP entered cycle 65; tx_done cycle 88.
REQ-033 N=2, fifo_empty=1 at cycle 128 -> tx_error pulse cycle 128, no load_byte, tx_done cycle 152.
REQ-034 tx_num_bytes=100 -> exactly 64 load_byte pulses, tx_done at cycle 8*(8*65+3)=4184; second tx_start at cycle 50 ignored.
REQ-035 n_rst low at cycle 70 of N=3 packet -> all outputs 0 immediately, no tx_done; new tx_start after release gives load_sync one cycle after acceptance.
REQ-036 TX_SEQ_ABORT_EN defined, N=3, tx_abort at cycle 100 -> EOP from 101, tx_eop high 101-116, tx_done 124, no tx_error; undefined: same stimulus -> tx_done at cycle 280.
